// File: rtl/fb_pkg.sv
// Framebuffer geometry, scan FSM states and the pixel address helper
// shared by the scanout block and its framebuffer RAM.
package fb_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = 15;

    localparam logic [7:0] LAST_X = 8'(FB_W - 1);
    localparam logic [6:0] LAST_Y = 7'(FB_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // Raster address of pixel (x,y); 15 bits covers the whole frame, no wrap.
    function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [7:0] x,
                                                        input logic [6:0] y);
        return FB_ADDR_W'(y) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one synchronous
// read port with one cycle of latency. A same-edge write and read of the
// same address returns the old contents. Contents are not reset.
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int WIDTH = 3,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and read-first read on the same edge; non-blocking update keeps
    // the read seeing the pre-write value.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: captures the vga_x/vga_y/vga_colour/vga_plot stream into a
// 160x120 framebuffer and, on a scan_start/scan_done level handshake, scans
// the frame in raster order as a valid/ready pixel stream.
// Optional build macro FB_CLIP_COUNT_EN: counts dropped out-of-range plots
// on clip_count (saturating); without it clip_count is tied to 0.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int COLOUR_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             vga_x,
    input  logic [6:0]             vga_y,
    input  logic [COLOUR_BITS-1:0] vga_colour,
    input  logic                   vga_plot,
    input  logic                   scan_start,
    output logic                   scan_done,
    output logic [7:0]             px_x,
    output logic [6:0]             px_y,
    output logic [COLOUR_BITS-1:0] px_colour,
    output logic                   px_valid,
    input  logic                   px_ready,
    output logic [15:0]            clip_count
);

    scan_state_t            state, state_n;
    logic [7:0]             x, x_n;
    logic [6:0]             y, y_n;
    logic [7:0]             px_x_n;
    logic [6:0]             px_y_n;
    logic [COLOUR_BITS-1:0] px_colour_n;
    logic                   px_valid_n, scan_done_n;
    logic                   rd_en;
    logic [FB_ADDR_W-1:0]   rd_addr;
    logic [COLOUR_BITS-1:0] rd_data;
    logic                   in_range, wr_en;
    logic [FB_ADDR_W-1:0]   wr_addr;

    // Write path is independent of the scan state.
    assign in_range = (vga_x <= LAST_X) && (vga_y <= LAST_Y);
    assign wr_en    = vga_plot && in_range;
    assign wr_addr  = xy_to_addr(vga_x, vga_y);
    // Reads always target the pixel the FSM is about to fetch.
    assign rd_addr  = xy_to_addr(x_n, y_n);

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (COLOUR_BITS),
        .AW    (FB_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (vga_colour),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Scan state, counters and presented-pixel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            px_x      <= '0;
            px_y      <= '0;
            px_colour <= '0;
            px_valid  <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            px_x      <= px_x_n;
            px_y      <= px_y_n;
            px_colour <= px_colour_n;
            px_valid  <= px_valid_n;
            scan_done <= scan_done_n;
        end
    end

    // Next-state logic; dropping scan_start mid-frame aborts back to IDLE.
    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        px_x_n      = px_x;
        px_y_n      = px_y;
        px_colour_n = px_colour;
        px_valid_n  = px_valid;
        scan_done_n = scan_done;
        rd_en       = 1'b0;
        case (state)
            IDLE: begin
                px_valid_n  = 1'b0;
                scan_done_n = 1'b0;
                if (scan_start) begin
                    x_n     = '0;
                    y_n     = '0;
                    rd_en   = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (!scan_start) begin
                    px_valid_n = 1'b0;
                    state_n    = IDLE;
                end else begin
                    px_colour_n = rd_data;
                    px_x_n      = x;
                    px_y_n      = y;
                    px_valid_n  = 1'b1;
                    state_n     = SHOW;
                end
            end
            SHOW: begin
                if (!scan_start) begin
                    px_valid_n = 1'b0;
                    state_n    = IDLE;
                end else if (px_ready) begin
                    px_valid_n = 1'b0;
                    if (x == LAST_X && y == LAST_Y) begin
                        scan_done_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        if (x == LAST_X) begin
                            x_n = '0;
                            y_n = y + 7'd1;
                        end else begin
                            x_n = x + 8'd1;
                        end
                        rd_en   = 1'b1;
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                scan_done_n = 1'b1;
                if (!scan_start) begin
                    scan_done_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef FB_CLIP_COUNT_EN
    logic [15:0] clip_q;

    // Saturating count of plots dropped for being off-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip_q <= '0;
        else if (vga_plot && !in_range && clip_q != 16'hFFFF)
            clip_q <= clip_q + 16'd1;
    end

    assign clip_count = clip_q;
`else
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a frame-array reference model, a scoreboard queue
// filled with the whole frame at scan start and a negedge monitor that pops
// and compares on every px_valid/px_ready handshake.
module tb_fb_scanout;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       scan_start;
    logic       scan_done;
    logic [7:0] px_x;
    logic [6:0] px_y;
    logic [2:0] px_colour;
    logic       px_valid;
    logic       px_ready;
    logic [15:0] clip_count;

    int   tests = 0;
    int   fails = 0;
    int   hs    = 0;
    int   model_clip = 0;
    logic [2:0] frame [N];
    pix_t exp_q [$];
    pix_t held, cur, e;
    bit   stall = 0;

    fb_scanout dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .scan_start (scan_start),
        .scan_done  (scan_done),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_colour  (px_colour),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: px_* must hold while stalled; each handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            cur = '{x: px_x, y: px_y, c: px_colour};
            if (stall && px_valid)
                chk("stable_while_stalled", 32'(cur), 32'(held));
            if (px_valid && px_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 32'(cur), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(cur), 32'(e));
                end
            end
            stall = px_valid && !px_ready;
            held  = cur;
        end
    end

    // One plot per cycle; model mirrors the spec's in-range/clip rules.
    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
        @(posedge clk); #1;
        vga_plot   = 1'b0;
        if (x < W && y < H)
            frame[y * W + x] = 3'(c);
        else if (model_clip < 16'hFFFF)
            model_clip++;
    endtask

    // Snapshot of the frame as it stands when the scan starts, in raster order.
    task automatic push_frame();
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back('{x: 8'(i % W), y: 7'(i / W), c: frame[i]});
    endtask

    // Wait (bounded) until pixel (x,y) is presented; optionally randomize px_ready.
    task automatic wait_px(input int x, input int y, input int budget, input bit rnd);
        bit found = 0;
        for (int n = 0; n < budget && !found; n++) begin
            @(posedge clk); #1;
            if (px_valid && px_x == 8'(x) && px_y == 7'(y))
                found = 1;
            else if (rnd)
                px_ready = 1'($urandom_range(0, 1));
        end
        chk("reach_pixel_in_budget", 32'(found), 32'd1);
    endtask

    int n;

    initial begin
        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        scan_start = 1'b0; px_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_px_valid", 32'(px_valid), 0);
        chk("rst_scan_done", 32'(scan_done), 0);
        chk("rst_px_x", 32'(px_x), 0);
        chk("rst_px_y", 32'(px_y), 0);
        chk("rst_px_colour", 32'(px_colour), 0);
        chk("rst_clip_count", 32'(clip_count), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill, random plots (some off-frame), corners, then explicit clips.
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                plot(xx, yy, 6);
        repeat (64) plot($urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 7));
        plot(0, 0, 5);
        plot(159, 119, 2);
        plot(160, 0, 1);
        plot(0, 120, 1);
        plot(255, 127, 1);
`ifdef FB_CLIP_COUNT_EN
        chk("clip_count", 32'(clip_count), 32'(model_clip));
`else
        chk("clip_count", 32'(clip_count), 0);
`endif

        // Full scan, px_ready tied high: 19200 pixels, done 38400 cycles after start.
        px_ready = 1'b1; scan_start = 1'b1; push_frame(); hs = 0;
        @(posedge clk);
        n = 0;
        while (n < 40000) begin
            @(posedge clk); #1;
            n++;
            if (scan_done) break;
        end
        chk("done_cycles", 32'(n), 32'd38400);
        chk("full_handshakes", 32'(hs), 32'(N));
        chk("full_queue_left", 32'(exp_q.size()), 0);
        chk("done_held", 32'(scan_done), 1);
        scan_start = 1'b0;
        @(posedge clk); #1;
        chk("done_cleared", 32'(scan_done), 0);

        // Random backpressure, abort while showing (10,5).
        scan_start = 1'b1; push_frame(); hs = 0;
        wait_px(10, 5, 10000, 1'b1);
        px_ready = 1'b0; scan_start = 1'b0;
        chk("abort_handshakes", 32'(hs), 32'd810);
        chk("abort_remaining", 32'(exp_q.size()), 32'(N - 810));
        @(posedge clk); #1;
        exp_q.delete();
        chk("abort_px_valid", 32'(px_valid), 0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_done", 32'(scan_done), 0);
            @(posedge clk); #1;
        end

        // Restart from (0,0); overwrite (20,20) on the edge that fetches it.
        px_ready = 1'b1; scan_start = 1'b1; push_frame(); hs = 0;
        wait_px(19, 20, 8000, 1'b0);
        plot(20, 20, 32'(~frame[20 * W + 20]));
        wait_px(25, 20, 100, 1'b0);
        chk("restart_handshakes", 32'(hs), 32'(20 * W + 25));

        // Async reset mid-scan: outputs clear before the next edge.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_px_valid", 32'(px_valid), 0);
        chk("midrst_scan_done", 32'(scan_done), 0);
        chk("midrst_clip_count", 32'(clip_count), 0);
        exp_q.delete(); model_clip = 0; scan_start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Next scan restarts at (0,0) with the RAM contents intact.
        scan_start = 1'b1; push_frame(); hs = 0;
        repeat (9) @(posedge clk);
        #1;
        chk("post_reset_handshakes", 32'(hs), 32'd4);
        scan_start = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
